// File: rtl/fetch_sequencer.sv
// Program counter and control-flow sequencer: decodes JMP/JSB/RET/BR from the fetched word.
// Define FETCH_RET_STACK_EN for a STACK_DEPTH-entry return stack; otherwise a single link register is used.
module fetch_sequencer #(
  parameter logic [11:0] RESET_PC    = 12'd0,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [18:0] instruction,
  input  logic        zero_flag,
  input  logic        carry_flag,
  output logic [11:0] address,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_sequencer: STACK_DEPTH must be a power of two in 2..16");
  end

  logic        is_jmp, is_jsb, is_ret, is_br, br_taken;
  logic        push_req, pop_req;
  logic        stk_full, stk_empty;
  logic [11:0] stk_top, pc_inc, br_target, next_pc;

  assign is_jmp = (instruction[18:12] == 7'b1110011);
  assign is_jsb = (instruction[18:12] == 7'b1110111);
  assign is_ret = (instruction[18:13] == 6'b111100);
  assign is_br  = (instruction[18:16] == 3'b101) && (instruction[13:8] == 6'b111000);

  always_comb begin
    br_taken = 1'b0;
    case (instruction[15:14])
      2'b00:   br_taken = zero_flag;
      2'b01:   br_taken = !zero_flag;
      2'b10:   br_taken = carry_flag;
      default: br_taken = !carry_flag;
    endcase
  end

  // All PC arithmetic is 12-bit, so wrap-around modulo 4096 falls out naturally.
  assign pc_inc    = address + 12'd1;
  assign br_target = pc_inc + {{4{instruction[7]}}, instruction[7:0]};

  always_comb begin
    next_pc  = pc_inc;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (is_jmp) begin
      next_pc = instruction[11:0];
    end else if (is_jsb) begin
      push_req = 1'b1;
      next_pc  = instruction[11:0];
    end else if (is_ret) begin
      pop_req = 1'b1;
      if (!stk_empty) next_pc = stk_top;
    end else if (is_br && br_taken) begin
      next_pc = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address         <= RESET_PC;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      address <= next_pc;
      if (pop_req && stk_empty) stack_underflow <= 1'b1;
    end
  end

`ifdef FETCH_RET_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [11:0]   stack_mem [STACK_DEPTH];
  logic [PW-1:0] count;
  logic [IW-1:0] top_idx;

  assign stk_full  = (count == PW'(STACK_DEPTH));
  assign stk_empty = (count == '0);
  // At count == STACK_DEPTH the low bits are zero, so the decrement wraps to the last entry.
  assign top_idx   = count[IW-1:0] - IW'(1);
  assign stk_top   = stack_mem[top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count          <= '0;
      stack_overflow <= 1'b0;
    end else if (!stall) begin
      if (push_req && !stk_full)      count <= count + PW'(1);
      else if (pop_req && !stk_empty) count <= count - PW'(1);
      if (push_req && stk_full) stack_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && push_req && !stk_full) stack_mem[count[IW-1:0]] <= pc_inc;
  end
`else
  logic [11:0] link;
  logic        link_valid;

  assign stk_full       = 1'b0;
  assign stk_empty      = !link_valid;
  assign stk_top        = link;
  assign stack_overflow = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link       <= '0;
      link_valid <= 1'b0;
    end else if (!stall) begin
      if (push_req) begin
        link       <= pc_inc;
        link_valid <= 1'b1;
      end else if (pop_req) begin
        link_valid <= 1'b0;
      end
    end
  end
`endif

  // Unused in this build, kept visible for debug of the push path.
  logic unused_full;
  assign unused_full = stk_full;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand sequences, random stream vs. model.
// Works in either build (FETCH_RET_STACK_EN defined or not).
module tb_fetch_sequencer;
  localparam logic [11:0] RST_PC = 12'd7;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [18:0] instruction = '0;
  logic        zero_flag = 1'b0;
  logic        carry_flag = 1'b0;
  logic [11:0] address;
  logic        stack_overflow, stack_underflow;

  fetch_sequencer #(.RESET_PC(RST_PC), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instruction(instruction),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .address(address),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_udf;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk_jmp(input int t);
    logic [11:0] tt = 12'(t);
    return {7'b1110011, tt};
  endfunction
  function automatic logic [18:0] mk_jsb(input int t);
    logic [11:0] tt = 12'(t);
    return {7'b1110111, tt};
  endfunction
  function automatic logic [18:0] mk_ret();
    return {6'b111100, 13'd0};
  endfunction
  function automatic logic [18:0] mk_br(input logic [1:0] cond, input logic [7:0] off);
    return {3'b101, cond, 6'b111000, off};
  endfunction
  localparam logic [18:0] NOP = 19'd0;

  task automatic model_reset();
    m_pc = RST_PC;
    m_stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic [18:0] ins, input logic z, input logic c, input logic st);
    int pc1, off;
    bit taken;
    if (st) return;
    pc1 = (m_pc + 1) % 4096;
    if (ins[18:14] == 5'b11100 && ins[13:12] == 2'b11) begin
      m_pc = int'(ins[11:0]);
    end else if (ins[18:14] == 5'b11101 && ins[13:12] == 2'b11) begin
`ifdef FETCH_RET_STACK_EN
      if (m_stk.size() < DEPTH) m_stk.push_back(pc1);
      else m_ovf = 1'b1;
`else
      m_stk.delete();
      m_stk.push_back(pc1);
`endif
      m_pc = int'(ins[11:0]);
    end else if (ins[18:13] == 6'b111100) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_udf = 1'b1;
        m_pc = pc1;
      end
    end else if (ins[18:16] == 3'b101 && ins[13:8] == 6'b111000) begin
      case (ins[15:14])
        2'd0: taken = z;
        2'd1: taken = !z;
        2'd2: taken = c;
        default: taken = !c;
      endcase
      off = int'($signed(ins[7:0]));
      m_pc = taken ? (m_pc + 1 + off + 4096) % 4096 : pc1;
    end else begin
      m_pc = pc1;
    end
  endtask

  // Called at a negedge: drive, let one rising edge happen, compare at the next negedge.
  task automatic cycle(input logic [18:0] ins, input logic z, input logic c, input logic st);
    instruction = ins;
    zero_flag   = z;
    carry_flag  = c;
    stall       = st;
    @(posedge clk);
    model_step(ins, z, c, st);
    @(negedge clk);
    check("address", int'(address), m_pc);
    check("stack_overflow", int'(stack_overflow), int'(m_ovf));
    check("stack_underflow", int'(stack_underflow), int'(m_udf));
  endtask

  typedef struct {
    logic [18:0] ins;
    logic        z;
    logic        c;
    logic        st;
    int          exp_addr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // directed table: expected addresses are the constants from the test plan
    vecs.push_back('{NOP, 0, 0, 0, 8});
    vecs.push_back('{NOP, 0, 0, 0, 9});
    vecs.push_back('{NOP, 0, 0, 0, 10});
    for (int i = 11; i <= 14; i++) vecs.push_back('{NOP, 0, 0, 0, i});
    vecs.push_back('{mk_jmp(20), 0, 0, 0, 20});
    vecs.push_back('{NOP, 0, 0, 0, 21});
    vecs.push_back('{mk_jsb(32), 0, 0, 0, 32});
    vecs.push_back('{NOP, 0, 0, 0, 33});
    vecs.push_back('{NOP, 0, 0, 0, 34});
    vecs.push_back('{mk_ret(), 0, 0, 0, 22});
    vecs.push_back('{mk_jmp(30), 0, 0, 0, 30});
    vecs.push_back('{mk_br(2'b00, 8'd8), 1, 0, 0, 39});
    vecs.push_back('{mk_jmp(30), 0, 0, 0, 30});
    vecs.push_back('{mk_br(2'b00, 8'd8), 0, 0, 0, 31});
    vecs.push_back('{mk_jmp(40), 0, 0, 0, 40});
    vecs.push_back('{mk_br(2'b10, 8'd17), 0, 1, 0, 58});
    vecs.push_back('{mk_jmp(50), 0, 0, 0, 50});
    vecs.push_back('{mk_jmp(100), 0, 0, 1, 50});
    vecs.push_back('{mk_jmp(100), 0, 0, 1, 50});
    vecs.push_back('{mk_jmp(100), 0, 0, 1, 50});
    vecs.push_back('{mk_jmp(100), 0, 0, 0, 100});
    vecs.push_back('{mk_jmp(2), 0, 0, 0, 2});
    vecs.push_back('{mk_br(2'b01, 8'hF0), 0, 0, 0, 4083});
    vecs.push_back('{mk_jmp(4095), 0, 0, 0, 4095});
    vecs.push_back('{NOP, 0, 0, 0, 0});
    vecs.push_back('{mk_br(2'b11, 8'h7F), 0, 1, 0, 1});

    // reset
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_address", int'(address), int'(RST_PC));
    check("reset_overflow", int'(stack_overflow), 0);
    check("reset_underflow", int'(stack_underflow), 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].ins, vecs[i].z, vecs[i].c, vecs[i].st);
      check("table_address", int'(address), vecs[i].exp_addr);
    end

    // nested subroutine calls past the stack depth, then unwind
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) cycle(mk_jsb(100 * i), 0, 0, 0);
    check("nested_jsb_target", int'(address), 900);
`ifdef FETCH_RET_STACK_EN
    check("nested_overflow_set", int'(stack_overflow), 1);
    for (int i = 8; i >= 1; i--) begin
      cycle(mk_ret(), 0, 0, 0);
      check("lifo_return", int'(address), (i == 1) ? 8 : 100 * (i - 1) + 1);
    end
    check("no_underflow_yet", int'(stack_underflow), 0);
    cycle(mk_ret(), 0, 0, 0);
    check("ninth_ret_pc", int'(address), 9);
    check("ninth_ret_underflow", int'(stack_underflow), 1);
`else
    check("link_overflow_tied", int'(stack_overflow), 0);
    cycle(mk_ret(), 0, 0, 0);
    check("link_return", int'(address), 801);
    cycle(mk_ret(), 0, 0, 0);
    check("link_empty_ret_pc", int'(address), 802);
    check("link_empty_underflow", int'(stack_underflow), 1);
`endif

    // reset asserted mid-cycle after two pushes
    cycle(mk_jmp(10), 0, 0, 0);
    cycle(mk_jsb(200), 0, 0, 0);
    cycle(mk_jsb(300), 0, 0, 0);
    instruction = NOP;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset_address", int'(address), int'(RST_PC));
    check("async_reset_underflow", int'(stack_underflow), 0);
    check("async_reset_overflow", int'(stack_overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(mk_ret(), 0, 0, 0);
    check("ret_after_reset_pc", int'(address), int'(RST_PC) + 1);
    check("ret_after_reset_underflow", int'(stack_underflow), 1);

    // random stream against the model
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [18:0] ins;
      logic [1:0]  cond;
      logic [7:0]  off;
      cond = 2'($urandom);
      off  = 8'($urandom);
      case ($urandom_range(0, 5))
        0: ins = mk_jmp($urandom_range(0, 4095));
        1: ins = mk_jsb($urandom_range(0, 4095));
        2: ins = mk_ret();
        3: ins = mk_br(cond, off);
        4: ins = NOP;
        default: ins = 19'($urandom);
      endcase
      cycle(ins, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
